multdiv_seq: RTL and testbench

MULTDIV_SEQ -- requirements
Module: multdiv_seq

---
 rtl/multdiv_pkg.sv | 18 +
 rtl/iter_downcounter5b.sv | 30 +++
 rtl/multdiv_seq.sv | 110 +++++++++++
 tb/tb_multdiv_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state encoding, iteration defaults and counter width
// for the multiply/divide sequencer.
`default_nettype none
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int MULT_ITERS_DEFAULT = 16;
  localparam int DIV_ITERS_DEFAULT  = 32;
  localparam int ITER_W             = 5;

endpackage
`default_nettype wire

// File: rtl/iter_downcounter5b.sv
// iter_downcounter5b: 5-bit iteration down-counter with synchronous preset,
// decrement enable, clear and zero flag. Saturates at zero.
`default_nettype none
module iter_downcounter5b
  import multdiv_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              preset,
  input  logic [ITER_W-1:0] preset_value,
  input  logic              dec,
  output logic [ITER_W-1:0] count,
  output logic              zero
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (preset) begin
      count <= preset_value;
    end else if (dec && (count != '0)) begin
      count <= count - ITER_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/multdiv_seq.sv
// multdiv_seq: IDLE/LOAD/RUN/DONE sequencer for an iterative multiply/divide
// datapath. Define MULTDIV_ABORT_EN to let a start during LOAD/RUN restart.
`default_nettype none
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int MULT_ITERS = MULT_ITERS_DEFAULT,
  parameter int DIV_ITERS  = DIV_ITERS_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_MULT,
  input  logic              ctrl_DIV,
  input  logic              divisor_zero,
  input  logic              overflow_in,
  output logic              load,
  output logic              step,
  output logic              op_is_div,
  output logic              busy,
  output logic [ITER_W-1:0] iter_count,
  output logic              data_resultRDY,
  output logic              data_exception
);

  localparam logic [ITER_W-1:0] MULT_LAST = ITER_W'(MULT_ITERS - 1);
  localparam logic [ITER_W-1:0] DIV_LAST  = ITER_W'(DIV_ITERS - 1);

  state_t state, state_next;
  logic   op_next;
  logic   exc, exc_next;
  logic   start, start_div;
  logic   cnt_zero, cnt_clear, cnt_preset, cnt_dec;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign start_div = ~ctrl_MULT & ctrl_DIV;  // multiply wins a tie

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_is_div <= 1'b0;
      exc       <= 1'b0;
    end else begin
      state     <= state_next;
      op_is_div <= op_next;
      exc       <= exc_next;
    end
  end

  always_comb begin
    state_next = state;
    op_next    = op_is_div;
    exc_next   = exc;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_LOAD;
          op_next    = start_div;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (op_is_div && divisor_zero) begin
          state_next = ST_DONE;
          exc_next   = 1'b1;
        end else begin
          state_next = ST_RUN;
          exc_next   = 1'b0;
        end
      end
      ST_RUN: begin
        // overflow is only meaningful on the edge closing the last multiply step
        if (cnt_zero) begin
          state_next = ST_DONE;
          exc_next   = ~op_is_div & overflow_in;
        end
      end
      default: state_next = ST_IDLE;
    endcase
`ifdef MULTDIV_ABORT_EN
    if (start && ((state == ST_LOAD) || (state == ST_RUN))) begin
      state_next = ST_LOAD;
      op_next    = start_div;
    end
`endif
  end

  assign cnt_preset = (state == ST_LOAD) && (state_next == ST_RUN);
  assign cnt_dec    = (state == ST_RUN) && (state_next == ST_RUN);
  assign cnt_clear  = (state_next != ST_RUN);

  iter_downcounter5b u_counter (
    .clock        (clock),
    .reset        (reset),
    .clear        (cnt_clear),
    .preset       (cnt_preset),
    .preset_value (op_is_div ? DIV_LAST : MULT_LAST),
    .dec          (cnt_dec),
    .count        (iter_count),
    .zero         (cnt_zero)
  );

  assign load           = (state == ST_LOAD);
  assign step           = (state == ST_RUN);
  assign busy           = (state == ST_LOAD) || (state == ST_RUN);
  assign data_resultRDY = (state == ST_DONE);
  assign data_exception = (state == ST_DONE) & exc;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: randomized self-checking bench for multdiv_seq against a
// cycle-offset timeline model of each operation.
`default_nettype none
module tb_multdiv_seq;

  localparam int MI = 16;
  localparam int DI = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ctrl_MULT = 1'b0;
  logic       ctrl_DIV = 1'b0;
  logic       divisor_zero = 1'b0;
  logic       overflow_in = 1'b0;
  logic       load, step, op_is_div, busy, data_resultRDY, data_exception;
  logic [4:0] iter_count;
  logic [10:0] obs;

  int passed = 0;
  int total  = 0;

  multdiv_seq #(.MULT_ITERS(MI), .DIV_ITERS(DI)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .divisor_zero   (divisor_zero),
    .overflow_in    (overflow_in),
    .load           (load),
    .step           (step),
    .op_is_div      (op_is_div),
    .busy           (busy),
    .iter_count     (iter_count),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception)
  );

  always #5 clock = ~clock;

  assign obs = {load, step, busy, op_is_div, data_resultRDY, data_exception, iter_count};

  // Expected output vector in the same packing as obs.
  function automatic logic [10:0] ev(bit ld, bit st, bit bz, bit od, bit rdy, bit ex, int cnt);
    logic [4:0] c;
    c = cnt[4:0];
    return {ld, st, bz, od, rdy, ex, c};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts one operation in the current cycle and follows it to its DONE
  // cycle, returning while still in that DONE cycle.
  task automatic run_op(input bit m, input bit d, input bit dz, input bit ovf_last, input string tag);
    bit od;
    int n;
    logic [10:0] e;
    od = !m && d;
    n  = od ? DI : MI;
    ctrl_MULT = m;
    ctrl_DIV  = d;
    tick();
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    divisor_zero = dz;
    e = ev(1, 0, 1, od, 0, 0, 0);
    total++;
    if (obs !== e) $display("FAIL %s load: got %b want %b", tag, obs, e);
    else passed++;
    tick();
    divisor_zero = 1'b0;
    if (od && dz) begin
      e = ev(0, 0, 0, 1, 1, 1, 0);
      total++;
      if (obs !== e) $display("FAIL %s divzero_done: got %b want %b", tag, obs, e);
      else passed++;
      return;
    end
    for (int k = 0; k < n; k++) begin
      overflow_in = (k == n - 1) ? ovf_last : 1'($urandom_range(0, 1));
      e = ev(0, 1, 1, od, 0, 0, n - 1 - k);
      total++;
      if (obs !== e) $display("FAIL %s run%0d: got %b want %b", tag, k, obs, e);
      else passed++;
      tick();
    end
    overflow_in = 1'b0;
    e = ev(0, 0, 0, od, 1, !od && ovf_last, 0);
    total++;
    if (obs !== e) $display("FAIL %s done: got %b want %b", tag, obs, e);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    total++;
    if (obs !== 11'd0) $display("FAIL reset_state: got %b want %b", obs, 11'd0);
    else passed++;
    reset = 1'b1;
    ctrl_MULT = 1'b1;
    ctrl_DIV  = 1'b1;
    tick();
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    total++;
    if (obs !== 11'd0) $display("FAIL reset_vs_start: got %b want %b", obs, 11'd0);
    else passed++;
    tick();
    total++;
    if (obs !== 11'd0) $display("FAIL reset_start_lost: got %b want %b", obs, 11'd0);
    else passed++;
  endtask

  task automatic test_single(input bit m, input bit d, input bit dz, input bit ovf, input string tag);
    logic [10:0] e;
    run_op(m, d, dz, ovf, tag);
    tick();
    e = ev(0, 0, 0, !m && d, 0, 0, 0);
    total++;
    if (obs !== e) $display("FAIL %s idle: got %b want %b", tag, obs, e);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    run_op(0, 1, 0, 0, "b2b_div");
    run_op(1, 0, 0, 1, "b2b_mult");
    run_op(0, 1, 1, 0, "b2b_divzero");
    tick();
    e = ev(0, 0, 0, 1, 0, 0, 0);
    total++;
    if (obs !== e) $display("FAIL b2b idle: got %b want %b", obs, e);
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic [10:0] e;
    bit seen;
    ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    tick();
    repeat (5) tick();
    e = ev(0, 1, 1, 0, 0, 0, MI - 1 - 5);
    total++;
    if (obs !== e) $display("FAIL midreset run5: got %b want %b", obs, e);
    else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (obs !== 11'd0) $display("FAIL midreset cleared: got %b want %b", obs, 11'd0);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (data_resultRDY || busy) seen = 1'b1;
      tick();
    end
    total++;
    if (seen !== 1'b0) $display("FAIL midreset activity: got %b want %b", seen, 1'b0);
    else passed++;
  endtask

  task automatic test_start_in_run();
    logic [10:0] e;
    int lat;
    int want_lat;
    ctrl_DIV = 1'b1;
    tick();
    ctrl_DIV = 1'b0;
    tick();
    repeat (3) tick();
    ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
`ifdef MULTDIV_ABORT_EN
    e = ev(1, 0, 1, 0, 0, 0, 0);
    want_lat = 1 + MI;
`else
    e = ev(0, 1, 1, 1, 0, 0, DI - 1 - 4);
    want_lat = DI - 4;
`endif
    total++;
    if (obs !== e) $display("FAIL start_in_run after: got %b want %b", obs, e);
    else passed++;
    lat = 0;
    while (!data_resultRDY && lat < 100) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== want_lat) $display("FAIL start_in_run latency: got %0d want %0d", lat, want_lat);
    else passed++;
`ifdef MULTDIV_ABORT_EN
    e = ev(0, 0, 0, 0, 1, 0, 0);
`else
    e = ev(0, 0, 0, 1, 1, 0, 0);
`endif
    total++;
    if (obs !== e) $display("FAIL start_in_run done: got %b want %b", obs, e);
    else passed++;
    tick();
  endtask

  task automatic test_random();
    bit m, d, dz, ovf, chain, od;
    logic [10:0] e;
    od = 1'b0;
    for (int i = 0; i < 10; i++) begin
      m     = 1'($urandom_range(0, 1));
      d     = 1'($urandom_range(0, 1));
      if (!m && !d) d = 1'b1;
      dz    = 1'($urandom_range(0, 1));
      ovf   = 1'($urandom_range(0, 1));
      chain = 1'($urandom_range(0, 1));
      od    = !m && d;
      run_op(m, d, dz, ovf, "random");
      if (!chain) begin
        tick();
        e = ev(0, 0, 0, od, 0, 0, 0);
        total++;
        if (obs !== e) $display("FAIL random idle: got %b want %b", obs, e);
        else passed++;
      end
    end
    tick();
    e = ev(0, 0, 0, od, 0, 0, 0);
    total++;
    if (obs !== e) $display("FAIL random final idle: got %b want %b", obs, e);
    else passed++;
  endtask

  initial begin
    #1;
    test_reset();
    test_single(1, 0, 0, 0, "mult");
    test_single(0, 1, 1, 0, "divzero");
    test_single(0, 1, 0, 1, "div");
    test_single(1, 0, 0, 1, "overflow");
    test_single(1, 1, 1, 1, "both_starts");
    test_back_to_back();
    test_mid_reset();
    test_start_in_run();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
